// File: rtl/uart_frame_timer.sv
// UART bit/frame timing generator shared by the TX and RX paths.
// Runtime divisor and frame format; emits mid-bit, bit-end and end-of-character strobes.
module uart_frame_timer #(
  parameter int unsigned CLK_FREQ     = 50_000_000,
  parameter int unsigned DEFAULT_BAUD = 115_200,
  parameter int unsigned DIV_W        = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_value,
  input  logic [1:0]       data_bits,
  input  logic             parity_en,
  input  logic             two_stop,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             middle,
  output logic             bitend,
  output logic [3:0]       bit_idx,
  output logic             charend,
  output logic             charended,
  output logic             div_err
);

  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(CLK_FREQ / DEFAULT_BAUD - 1);
  localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(3);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state, state_nx;
  logic [DIV_W-1:0] div, div_nx;
  logic [DIV_W-1:0] clk_cnt, cnt_nx;
  logic [3:0]       idx_nx;
  logic [3:0]       last_idx, last_nx;
  logic             charended_nx;
  logic             div_err_nx;

  logic             run;
  logic             mid_hit;
  logic             end_hit;
  logic             last_bit;
  logic             div_ok;
  logic [3:0]       fmt_last;

  // Index of the last stop-bit slot (frame length minus one) for the current format inputs.
  always_comb begin
    fmt_last = 4'd5 + {2'b00, data_bits} + {3'b000, parity_en} + (two_stop ? 4'd2 : 4'd1);
  end

  always_comb begin
    run      = (state == RUN);
    mid_hit  = (clk_cnt == (div >> 1));
    end_hit  = (clk_cnt == div);
    last_bit = (bit_idx == last_idx);
    div_ok   = (div_value >= DIV_MIN);

    busy     = run;
    middle   = run && mid_hit;
    bitend   = run && end_hit;
    charend  = middle && last_bit;
  end

  always_comb begin
    state_nx     = state;
    div_nx       = div;
    cnt_nx       = clk_cnt;
    idx_nx       = bit_idx;
    last_nx      = last_idx;
    charended_nx = charended;
    div_err_nx   = 1'b0;

    // The divisor only changes between frames; a load while running is flagged, not applied.
    if (div_load) begin
      if (!run && div_ok) begin
        div_nx = div_value;
      end else begin
        div_err_nx = 1'b1;
      end
    end

    if (abort) begin
      state_nx     = IDLE;
      cnt_nx       = '0;
      idx_nx       = '0;
      charended_nx = 1'b1;
    end else if (start) begin
      state_nx     = RUN;
      cnt_nx       = '0;
      idx_nx       = '0;
      last_nx      = fmt_last;
      charended_nx = 1'b0;
    end else if (run) begin
      if (end_hit) begin
        cnt_nx = '0;
        if (last_bit) begin
          state_nx     = IDLE;
          idx_nx       = '0;
          charended_nx = 1'b1;
        end else begin
          idx_nx = bit_idx + 4'd1;
        end
      end else begin
        cnt_nx = clk_cnt + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      div       <= DIV_RST;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      last_idx  <= 4'd9;
      charended <= 1'b1;
      div_err   <= 1'b0;
    end else begin
      state     <= state_nx;
      div       <= div_nx;
      clk_cnt   <= cnt_nx;
      bit_idx   <= idx_nx;
      last_idx  <= last_nx;
      charended <= charended_nx;
      div_err   <= div_err_nx;
    end
  end

endmodule

// File: tb/tb_uart_frame_timer.sv
// Bench for uart_frame_timer: elapsed-time frame model checked every cycle,
// plus literal event-cycle expectations for each directed scenario.
module tb_uart_frame_timer;

  localparam int DEF_DIV = 433;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        div_load = 1'b0;
  logic [19:0] div_value = '0;
  logic [1:0]  data_bits = 2'd3;
  logic        parity_en = 1'b0;
  logic        two_stop = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        busy, middle, bitend, charend, charended, div_err;
  logic [3:0]  bit_idx;

  uart_frame_timer #(
    .CLK_FREQ    (50_000_000),
    .DEFAULT_BAUD(115_200),
    .DIV_W       (20)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .div_load (div_load),
    .div_value(div_value),
    .data_bits(data_bits),
    .parity_en(parity_en),
    .two_stop (two_stop),
    .start    (start),
    .abort    (abort),
    .busy     (busy),
    .middle   (middle),
    .bitend   (bitend),
    .bit_idx  (bit_idx),
    .charend  (charend),
    .charended(charended),
    .div_err  (div_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a frame is just elapsed cycles k since start; slot = k/(div+1), phase = k%(div+1).
  bit m_run = 1'b0;
  bit m_err = 1'b0;
  int m_k = 0;
  int m_div = DEF_DIV;
  int m_n = 10;

  // Event recorder, cycle 0 = first cycle after the start edge.
  int since = 0;
  int first_mid = -1, first_be = -1, n_mid = 0, n_be = 0, n_ce = 0;
  int ce_cyc = -1, ced_cyc = -1, max_bit = 0;
  bit prev_ced = 1'b1;

  always @(posedge clk) begin
    bit st;
    int per, b, c;
    bit e_mid, e_be, e_ce;
    st = !rst && !abort && start;
    if (rst) begin
      m_run = 1'b0;
      m_err = 1'b0;
      m_k   = 0;
      m_div = DEF_DIV;
    end else begin
      m_err = div_load && (m_run || int'(div_value) < 3);
      if (div_load && !m_run && int'(div_value) >= 3) m_div = int'(div_value);
      if (abort) begin
        m_run = 1'b0;
      end else if (start) begin
        m_run = 1'b1;
        m_k   = 0;
        m_n   = 1 + (int'(data_bits) + 5) + int'(parity_en) + (two_stop ? 2 : 1);
      end else if (m_run) begin
        m_k++;
        if (m_k == m_n * (m_div + 1)) m_run = 1'b0;
      end
    end
    if (st) begin
      since = 0; first_mid = -1; first_be = -1; n_mid = 0; n_be = 0; n_ce = 0;
      ce_cyc = -1; ced_cyc = -1; max_bit = 0;
    end else begin
      since++;
    end
    #1;
    if (chk_en) begin
      per   = m_div + 1;
      b     = m_run ? m_k / per : 0;
      c     = m_k % per;
      e_mid = m_run && (c == m_div / 2);
      e_be  = m_run && (c == m_div);
      e_ce  = e_mid && (b == m_n - 1);
      check("busy", busy, m_run);
      check("middle", middle, e_mid);
      check("bitend", bitend, e_be);
      check("charend", charend, e_ce);
      check("charended", charended, !m_run);
      check("bit_idx", bit_idx, b);
      check("div_err", div_err, m_err);
    end
    if (middle) begin n_mid++; if (first_mid < 0) first_mid = since; end
    if (bitend) begin n_be++; if (first_be < 0) first_be = since; end
    if (charend) begin n_ce++; ce_cyc = since; end
    if (charended && !prev_ced) ced_cyc = since;
    prev_ced = charended;
    if (int'(bit_idx) > max_bit) max_bit = int'(bit_idx);
  end

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic load_div(input int v);
    @(negedge clk); div_load = 1'b1; div_value = 20'(v);
    @(negedge clk); div_load = 1'b0;
  endtask

  task automatic set_fmt(input int db, input bit par, input bit ts);
    data_bits = 2'(db); parity_en = par; two_stop = ts;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    do begin @(negedge clk); n++; end while (busy === 1'b1 && n < limit);
    check("idle_timeout", busy, 0);
  endtask

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_busy", busy, 0);
    check("rst_charended", charended, 1);
    check("rst_bit_idx", bit_idx, 0);
    check("rst_strobes", {middle, bitend, charend, div_err}, 0);
    rst = 1'b0;

    // 1: default div 433, 8N1
    set_fmt(3, 0, 0);
    do_start();
    wait_idle(5000);
    check("t1_first_mid", first_mid, 216);
    check("t1_first_be", first_be, 433);
    check("t1_n_be", n_be, 10);
    check("t1_charend", ce_cyc, 4122);
    check("t1_charended", ced_cyc, 4340);

    // 2: div_load 9 together with start, 7E1
    @(negedge clk);
    set_fmt(2, 1, 0);
    div_load = 1'b1; div_value = 20'd9; start = 1'b1;
    @(negedge clk); div_load = 1'b0; start = 1'b0;
    wait_idle(200);
    check("t2_first_mid", first_mid, 4);
    check("t2_n_mid", n_mid, 10);
    check("t2_charended", ced_cyc, 100);

    // 3: 5N1 at div 9
    load_div(9);
    set_fmt(0, 0, 0);
    do_start();
    wait_idle(200);
    check("t3_charend", ce_cyc, 64);
    check("t3_busy_fall", ced_cyc, 70);
    check("t3_max_bit", max_bit, 6);

    // 4: 8E2, format inputs disturbed mid-frame
    set_fmt(3, 1, 1);
    do_start();
    repeat (30) @(negedge clk);
    set_fmt(0, 0, 0);
    wait_idle(200);
    check("t4_charend", ce_cyc, 114);
    check("t4_charended", ced_cyc, 120);

    // 5: rejected divisor loads
    load_div(2);
    check("t5_err_small", div_err, 1);
    @(negedge clk);
    check("t5_err_pulse", div_err, 0);
    set_fmt(3, 0, 0);
    do_start();
    repeat (20) @(negedge clk);
    load_div(20);
    check("t5_err_run", div_err, 1);
    wait_idle(200);
    check("t5_charended", ced_cyc, 100);

    // 6: abort at cycle 35, no charend
    do_start();
    repeat (34) @(negedge clk);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("t6_abort_busy", busy, 0);
    check("t6_abort_ced", charended, 1);
    repeat (60) @(negedge clk);
    check("t6_abort_nce", n_ce, 0);

    // Restart at bit 4
    do_start();
    begin
      int n = 0;
      while (bit_idx !== 4'd4 && n < 100) begin @(negedge clk); n++; end
      check("t6_reach_bit4", bit_idx, 4);
    end
    do_start();
    check("t6_restart_idx", bit_idx, 0);
    check("t6_restart_be", bitend, 0);
    wait_idle(200);
    check("t6_restart_ced", ced_cyc, 100);

    // start and abort together
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    check("t6_sa_busy", busy, 0);
    check("t6_sa_ced", charended, 1);

    // rst mid-frame restores the default divisor
    do_start();
    repeat (50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_idx", bit_idx, 0);
    check("t6_rst_ced", charended, 1);
    do_start();
    begin
      int n = 0;
      while (first_mid < 0 && n < 400) begin @(negedge clk); n++; end
    end
    check("t6_rst_div", first_mid, 216);
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
